// File: rtl/minpool_pkg.sv
`default_nettype none
// ============================================================================
// Module      : minpool_pkg
// Description : Shared defaults and the output-size rule for minpool.
// Revision    : 1.0
// ============================================================================
package minpool_pkg;

    localparam int MP_DATA_WIDTH = 8;
    localparam int MP_IN_DIM     = 8;
    localparam int MP_WIN        = 3;

    // Valid (unpadded) stride-1 window positions along one axis.
    function automatic int mp_out_dim(input int in_dim, input int win);
        return in_dim - win + 1;
    endfunction

endpackage : minpool_pkg
`default_nettype wire

// File: rtl/minpool_min3.sv
`default_nettype none
// ============================================================================
// Module      : min3
// Description : Combinational unsigned minimum of three equal-width operands.
// Revision    : 1.0
// ============================================================================
module min3 #(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic [DATA_WIDTH-1:0] c,
    output logic [DATA_WIDTH-1:0] y
);

    logic [DATA_WIDTH-1:0] w_ab;

    always_comb begin
        w_ab = (b < a) ? b : a;
        y    = (c < w_ab) ? c : w_ab;
    end

endmodule : min3
`default_nettype wire

// File: rtl/minpool.sv
`default_nettype none
// ============================================================================
// Module      : minpool
// Description : Two-stage pipelined WIN x WIN stride-1 unsigned min pooling.
// Revision    : 1.0
// ============================================================================
module minpool
    import minpool_pkg::*;
#(
    parameter  int DATA_WIDTH = MP_DATA_WIDTH,
    parameter  int IN_DIM     = MP_IN_DIM,
    parameter  int WIN        = MP_WIN,
    localparam int OUT_DIM    = mp_out_dim(IN_DIM, WIN)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] feature_map [IN_DIM][IN_DIM],
    output logic [DATA_WIDTH-1:0] pooled_map  [OUT_DIM][OUT_DIM]
);

    logic [DATA_WIDTH-1:0] row_min_d    [IN_DIM][OUT_DIM];
    logic [DATA_WIDTH-1:0] row_min_q    [IN_DIM][OUT_DIM];
    logic [DATA_WIDTH-1:0] pooled_map_d [OUT_DIM][OUT_DIM];
    logic [DATA_WIDTH-1:0] pooled_map_q [OUT_DIM][OUT_DIM];

    // Stage 1: horizontal reduction of every input row.
    for (genvar r = 0; r < IN_DIM; r++) begin : g_row
        for (genvar c = 0; c < OUT_DIM; c++) begin : g_col
            if (WIN == 3) begin : g_min3
                min3 #(
                    .DATA_WIDTH (DATA_WIDTH)
                ) u_row_min (
                    .a (feature_map[r][c]),
                    .b (feature_map[r][c+1]),
                    .c (feature_map[r][c+2]),
                    .y (row_min_d[r][c])
                );
            end else begin : g_minn
                always_comb begin
                    logic [DATA_WIDTH-1:0] acc;
                    acc = feature_map[r][c];
                    for (int k = 1; k < WIN; k++) begin
                        if (feature_map[r][c+k] < acc) begin
                            acc = feature_map[r][c+k];
                        end
                    end
                    row_min_d[r][c] = acc;
                end
            end
        end
    end

    // Stage 2: vertical reduction of the registered row minima.
    for (genvar r = 0; r < OUT_DIM; r++) begin : g_out_row
        for (genvar c = 0; c < OUT_DIM; c++) begin : g_out_col
            if (WIN == 3) begin : g_min3
                min3 #(
                    .DATA_WIDTH (DATA_WIDTH)
                ) u_col_min (
                    .a (row_min_q[r][c]),
                    .b (row_min_q[r+1][c]),
                    .c (row_min_q[r+2][c]),
                    .y (pooled_map_d[r][c])
                );
            end else begin : g_minn
                always_comb begin
                    logic [DATA_WIDTH-1:0] acc;
                    acc = row_min_q[r][c];
                    for (int k = 1; k < WIN; k++) begin
                        if (row_min_q[r+k][c] < acc) begin
                            acc = row_min_q[r+k][c];
                        end
                    end
                    pooled_map_d[r][c] = acc;
                end
            end
        end
    end

    // Clearing both stages on reset guarantees no in-flight map leaks out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < IN_DIM; r++) begin
                for (int c = 0; c < OUT_DIM; c++) begin
                    row_min_q[r][c] <= '0;
                end
            end
            for (int r = 0; r < OUT_DIM; r++) begin
                for (int c = 0; c < OUT_DIM; c++) begin
                    pooled_map_q[r][c] <= '0;
                end
            end
        end else begin
            for (int r = 0; r < IN_DIM; r++) begin
                for (int c = 0; c < OUT_DIM; c++) begin
                    row_min_q[r][c] <= row_min_d[r][c];
                end
            end
            for (int r = 0; r < OUT_DIM; r++) begin
                for (int c = 0; c < OUT_DIM; c++) begin
                    pooled_map_q[r][c] <= pooled_map_d[r][c];
                end
            end
        end
    end

    assign pooled_map = pooled_map_q;

endmodule : minpool
`default_nettype wire

// File: tb/tb_minpool.sv
`default_nettype none
// ============================================================================
// Module      : tb_minpool
// Description : Self-checking bench for minpool against a window-min model.
// Revision    : 1.0
// ============================================================================
module tb_minpool;

    localparam int DW  = 8;
    localparam int IND = 8;
    localparam int W   = 3;
    localparam int OD  = IND - W + 1;

    logic          clk;
    logic          rst;
    logic [DW-1:0] fm         [IND][IND];
    logic [DW-1:0] pooled_map [OD][OD];

    // Model state: map seen at the previous edge and whether it was accepted.
    logic [DW-1:0] prev_map   [IND][IND];
    bit            prev_valid;
    logic [DW-1:0] exp_map    [OD][OD];

    int checks = 0;
    int errors = 0;

    minpool #(
        .DATA_WIDTH (DW),
        .IN_DIM     (IND),
        .WIN        (W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .feature_map (fm),
        .pooled_map  (pooled_map)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_exp_zero();
        for (int r = 0; r < OD; r++)
            for (int c = 0; c < OD; c++)
                exp_map[r][c] = '0;
    endtask

    // Direct definition: minimum over the WIN x WIN window anchored at (r,c).
    task automatic golden_from_prev();
        for (int r = 0; r < OD; r++) begin
            for (int c = 0; c < OD; c++) begin
                int m;
                m = 255;
                for (int i = 0; i < W; i++)
                    for (int j = 0; j < W; j++)
                        if (int'(prev_map[r+i][c+j]) < m) m = int'(prev_map[r+i][c+j]);
                exp_map[r][c] = DW'(m);
            end
        end
    endtask

    // One rising edge, then the model is advanced and the output checked.
    task automatic tick(input string tag);
        @(posedge clk);
        if (prev_valid && !rst) golden_from_prev();
        else set_exp_zero();
        prev_valid = !rst;
        prev_map   = fm;
        @(negedge clk);
        check_map(tag);
    endtask

    task automatic check_map(input string tag);
        int bad, br, bc;
        bad = 0; br = 0; bc = 0;
        for (int r = 0; r < OD; r++)
            for (int c = 0; c < OD; c++)
                if (pooled_map[r][c] !== exp_map[r][c]) begin
                    if (bad == 0) begin br = r; bc = c; end
                    bad++;
                end
        checks++;
        assert (bad === 0) else begin
            errors++;
            $error("FAIL %s: %0d elements differ, first [%0d][%0d] observed %0h expected %0h",
                   tag, bad, br, bc, pooled_map[br][bc], exp_map[br][bc]);
        end
    endtask

    task automatic check_elem(input string tag, input int r, input int c, input logic [DW-1:0] v);
        checks++;
        assert (pooled_map[r][c] === v) else begin
            errors++;
            $error("FAIL %s: [%0d][%0d] observed %0h expected %0h", tag, r, c, pooled_map[r][c], v);
        end
    endtask

    task automatic fill_random();
        for (int r = 0; r < IND; r++)
            for (int c = 0; c < IND; c++)
                fm[r][c] = DW'($urandom_range(0, 255));
    endtask

    task automatic fill_const(input logic [DW-1:0] v);
        for (int r = 0; r < IND; r++)
            for (int c = 0; c < IND; c++)
                fm[r][c] = v;
    endtask

    initial begin
        prev_valid = 1'b0;
        rst = 1'b1;
        fill_random();
        prev_map = fm;
        set_exp_zero();

        // Reset is asynchronous: outputs are zero before any clock edge.
        #2;
        check_map("reset_async");
        tick("reset_hold1");
        fill_random();
        tick("reset_hold2");

        rst = 1'b0;
        fill_random();
        tick("post_rst_edge1");
        fill_random();
        tick("post_rst_edge2");

        fill_const(8'h5A);
        tick("uniform_a");
        tick("uniform_b");
        check_elem("uniform_spot", 5, 5, 8'h5A);

        for (int r = 0; r < IND; r++)
            for (int c = 0; c < IND; c++)
                fm[r][c] = DW'(8 * r + c);
        tick("ramp_a");
        tick("ramp_b");
        check_elem("ramp_spot", 4, 3, 8'd35);

        fill_const(8'hFF);
        fm[3][4] = 8'h01;
        tick("single_min_a");
        tick("single_min_b");
        check_elem("single_min_in", 1, 2, 8'h01);
        check_elem("single_min_in2", 3, 4, 8'h01);
        check_elem("single_min_out", 0, 4, 8'hFF);
        check_elem("single_min_out2", 3, 5, 8'hFF);

        fill_const(8'h80);
        fm[0][0] = 8'h7F;
        tick("unsigned_a");
        tick("unsigned_b");
        check_elem("unsigned_corner", 0, 0, 8'h7F);
        check_elem("unsigned_other", 0, 1, 8'h80);

        // Back-to-back random maps: each result appears two edges later.
        for (int k = 0; k < 3; k++) begin
            fill_random();
            tick("stream");
        end
        tick("stream_drain1");
        tick("stream_drain2");

        // Reset pulse mid-stream drops in-flight maps.
        fill_random();
        tick("pre_reset");
        fill_random();
        #2;
        rst = 1'b1;
        #1;
        prev_valid = 1'b0;
        set_exp_zero();
        check_map("midstream_rst_async");
        @(negedge clk);
        check_map("midstream_rst_hold");
        rst = 1'b0;
        fill_random();
        tick("after_rst_edge1");
        fill_random();
        tick("after_rst_edge2");

        // Random soak, including low-range values to stress ties.
        for (int k = 0; k < 20; k++) begin
            if (k % 4 == 0) begin
                for (int r = 0; r < IND; r++)
                    for (int c = 0; c < IND; c++)
                        fm[r][c] = DW'($urandom_range(0, 3));
            end else begin
                fill_random();
            end
            tick("random");
        end
        tick("random_drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_minpool
`default_nettype wire
